// File: rtl/uart_core_bridge_pkg.sv
// Shared definitions for the UART core bridge: FSM state types and 8N1 frame constants.
package uart_core_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RESP,
        R_WAIT
    } resp_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

    // Guards against a zero-width counter when a bit lasts a single clock.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO succeeds only when a pop frees the slot on the same edge.
module sync_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_core_bridge.sv
// Core-side UART responder: buffers received bytes for core requests and serializes core TX bytes as 8N1 on txd.
module uart_core_bridge
    import uart_core_bridge_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next,
    output logic       rx_ready,
    output logic [7:0] rdata,
    input  logic       tx_ready,
    input  logic [7:0] sdata,
    input  logic       rx_byte_valid,
    input  logic [7:0] rx_byte,
    output logic       txd,
    output logic       tx_busy,
    output logic       rx_overflow,
    output logic       tx_overflow
);

    localparam int unsigned     CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

    logic [7:0]  w_rx_dout;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_rx_pop;
    resp_state_t r_resp_state;
    resp_state_t w_resp_next;
    logic        r_rx_ready;
    logic [7:0]  r_rdata;
    logic        r_rx_ovf;

    logic [7:0]  w_tx_dout;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_tx_pop;
    tx_state_t   r_tx_state;
    tx_state_t   w_tx_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [7:0]  r_shreg;
    logic        r_txd;
    logic        w_txd_next;
    logic        w_bit_last;
    logic        r_tx_ovf;

    sync_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_byte_valid),
        .pop   (w_rx_pop),
        .din   (rx_byte),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    sync_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_ready),
        .pop   (w_tx_pop),
        .din   (sdata),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    // R_RESP absorbs the edge where the core has not yet seen rx_ready and still holds next.
    always_comb begin
        w_resp_next = r_resp_state;
        w_rx_pop    = 1'b0;
        case (r_resp_state)
            R_IDLE: begin
                if (next && !w_rx_empty) begin
                    w_rx_pop    = 1'b1;
                    w_resp_next = R_RESP;
                end
            end
            R_RESP:  w_resp_next = R_WAIT;
            R_WAIT:  if (!next) w_resp_next = R_IDLE;
            default: w_resp_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_state <= R_IDLE;
            r_rx_ready   <= 1'b0;
            r_rdata      <= '0;
            r_rx_ovf     <= 1'b0;
        end else begin
            r_resp_state <= w_resp_next;
            r_rx_ready   <= w_rx_pop;
            if (w_rx_pop) r_rdata <= w_rx_dout;
            if (rx_byte_valid && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
        end
    end

    assign w_bit_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_tx_next  = r_tx_state;
        w_cnt_next = r_cnt + 1'b1;
        w_idx_next = r_idx;
        w_tx_pop   = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                w_cnt_next = '0;
                if (!w_tx_empty) begin
                    w_tx_pop  = 1'b1;
                    w_tx_next = T_START;
                end
            end
            T_START: begin
                if (w_bit_last) begin
                    w_cnt_next = '0;
                    w_idx_next = '0;
                    w_tx_next  = T_DATA;
                end
            end
            T_DATA: begin
                if (w_bit_last) begin
                    w_cnt_next = '0;
                    if (r_idx == IDX_LAST) w_tx_next  = T_STOP;
                    else                   w_idx_next = r_idx + 1'b1;
                end
            end
            T_STOP: begin
                if (w_bit_last) begin
                    w_cnt_next = '0;
                    w_tx_next  = T_IDLE;
                end
            end
            default: w_tx_next = T_IDLE;
        endcase

        // txd is registered from the upcoming state so the pin follows the state with no glitch.
        case (w_tx_next)
            T_START: w_txd_next = START_BIT;
            T_DATA:  w_txd_next = r_shreg[w_idx_next];
            default: w_txd_next = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shreg    <= '0;
            r_txd      <= STOP_BIT;
            r_tx_ovf   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_cnt      <= w_cnt_next;
            r_idx      <= w_idx_next;
            r_txd      <= w_txd_next;
            if (w_tx_pop) r_shreg <= w_tx_dout;
            if (tx_ready && w_tx_full && !w_tx_pop) r_tx_ovf <= 1'b1;
        end
    end

    assign rx_ready    = r_rx_ready;
    assign rdata       = r_rdata;
    assign txd         = r_txd;
    assign tx_busy     = ~w_tx_empty | (r_tx_state != T_IDLE);
    assign rx_overflow = r_rx_ovf;
    assign tx_overflow = r_tx_ovf;

endmodule

// File: tb/tb_uart_core_bridge.sv
// Self-checking bench for uart_core_bridge: vector table, directed corner sequences and randomized traffic.
module tb_uart_core_bridge;

    localparam int unsigned CPB = 4;
    localparam int unsigned NV  = 19;

    logic       clk = 1'b0;
    logic       rst;
    logic       next;
    logic       rx_ready;
    logic [7:0] rdata;
    logic       tx_ready;
    logic [7:0] sdata;
    logic       rx_byte_valid;
    logic [7:0] rx_byte;
    logic       txd;
    logic       tx_busy;
    logic       rx_overflow;
    logic       tx_overflow;

    int n_checks = 0;
    int n_errors = 0;

    uart_core_bridge #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .next          (next),
        .rx_ready      (rx_ready),
        .rdata         (rdata),
        .tx_ready      (tx_ready),
        .sdata         (sdata),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte       (rx_byte),
        .txd           (txd),
        .tx_busy       (tx_busy),
        .rx_overflow   (rx_overflow),
        .tx_overflow   (tx_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       nxt;
        logic       vld;
        logic [7:0] byt;
        logic       exp_rdy;
        logic [7:0] exp_data;
    } rx_vec_t;

    rx_vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // TX reference: a queue of pending bytes and a frame timer; a frame lasts 10*CPB cycles
    // and the next byte may only leave the queue after one idle cycle.
    logic [7:0]  m_q [$];
    logic [7:0]  m_cur  = 8'h00;
    int unsigned m_busy = 0;
    int unsigned m_pos  = 0;
    logic        m_ovf  = 1'b0;
    bit          m_pop;
    bit          m_full;
    bit          tx_chk_en = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int unsigned p);
        int unsigned s;
        s = p / CPB;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_busy = 0;
            m_pos  = 0;
            m_ovf  = 1'b0;
        end else begin
            m_pop  = (m_busy == 0) && (m_q.size() > 0);
            m_full = (m_q.size() >= 16);
            if (m_pop) m_cur = m_q.pop_front();
            if (tx_ready) begin
                if (!m_full || m_pop) m_q.push_back(sdata);
                else                  m_ovf = 1'b1;
            end
            if (m_pop) begin
                m_busy = 10 * CPB;
                m_pos  = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_chk_en) begin
            chk("model_txd", txd, (m_busy > 0) ? frame_bit(m_cur, m_pos) : 1'b1);
            chk("model_tx_busy", tx_busy, (m_busy > 0) || (m_q.size() > 0));
            chk("model_tx_overflow", tx_overflow, m_ovf);
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    logic [9:0]  fr;
    logic [7:0]  exp_b;
    logic [7:0]  sb [$];
    bit          got;
    bit          core_req;
    int          cool;
    int          wcnt;

    initial begin
        rst = 1'b1; next = 1'b0; tx_ready = 1'b0; sdata = '0; rx_byte_valid = 1'b0; rx_byte = '0;

        vec[0]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00};
        vec[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41};
        vec[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h41};
        vec[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h41};
        vec[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h41};
        vec[5]  = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h41};
        vec[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h5A};
        vec[7]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h5A};
        vec[8]  = '{1'b1, 1'b1, 8'h22, 1'b0, 8'h5A};
        vec[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h5A};
        vec[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h5A};
        vec[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h11};
        vec[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h11};
        vec[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h11};
        vec[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h22};
        vec[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h22};
        vec[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h22};
        vec[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h22};
        vec[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h22};

        repeat (3) step();
        rst = 1'b0;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_txd", txd, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_overflow", rx_overflow, 0);
        chk("rst_tx_overflow", tx_overflow, 0);
        tx_chk_en = 1'b1;

        // RX handshake vectors, including a core that holds next 3 cycles past rx_ready.
        for (int i = 0; i < NV; i++) begin
            next = vec[i].nxt;
            rx_byte_valid = vec[i].vld;
            rx_byte = vec[i].byt;
            step();
            rx_byte_valid = 1'b0;
            chk($sformatf("rxvec%0d_rx_ready", i), rx_ready, vec[i].exp_rdy);
            chk($sformatf("rxvec%0d_rdata", i), rdata, vec[i].exp_data);
        end

        // Single 0xA5 frame, bit by bit.
        fr = {1'b1, 8'hA5, 1'b0};
        sdata = 8'hA5; tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("a5_idle_before_start", txd, 1);
        chk("a5_busy_queued", tx_busy, 1);
        for (int j = 0; j < 40; j++) begin
            step();
            chk($sformatf("a5_txd_cyc%0d", j), txd, fr[j / CPB]);
        end
        step();
        chk("a5_busy_after", tx_busy, 0);
        chk("a5_txd_after", txd, 1);

        // RX overflow: 17 strobes with no requests, then drain.
        for (int i = 0; i < 17; i++) begin
            rx_byte_valid = 1'b1; rx_byte = 8'(i * 37 + 5);
            step();
            if (i == 15) chk("rxovf_not_yet", rx_overflow, 0);
        end
        rx_byte_valid = 1'b0;
        chk("rxovf_set", rx_overflow, 1);
        for (int i = 0; i < 16; i++) begin
            next = 1'b1; got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                step();
                if (rx_ready) got = 1'b1;
            end
            chk($sformatf("rxovf_seen%0d", i), got, 1);
            exp_b = 8'(i * 37 + 5);
            chk($sformatf("rxovf_data%0d", i), rdata, exp_b);
            next = 1'b0;
            step(); step();
        end
        next = 1'b1; got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (rx_ready) got = 1'b1;
        end
        chk("rxovf_17th_dropped", got, 0);
        next = 1'b0;
        step(); step();

        // TX overflow: one frame in flight, then 17 back-to-back pulses.
        sdata = 8'h3C; tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        step();
        for (int i = 0; i < 17; i++) begin
            sdata = 8'(8'h80 + i); tx_ready = 1'b1;
            step();
            if (i == 15) chk("txovf_not_yet", tx_overflow, 0);
        end
        tx_ready = 1'b0;
        chk("txovf_set", tx_overflow, 1);

        // Queue RX bytes that reset must discard, then reset in the middle of a data bit.
        rx_byte_valid = 1'b1; rx_byte = 8'hC3;
        step();
        rx_byte = 8'h3C;
        step();
        rx_byte_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (m_busy > 0 && m_pos >= 2 * CPB && m_pos < 8 * CPB) got = 1'b1;
            else step();
        end
        chk("mid_data_reached", got, 1);
        chk("rx_overflow_sticky", rx_overflow, 1);
        chk("tx_overflow_sticky", tx_overflow, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_txd", txd, 1);
        chk("midrst_tx_busy", tx_busy, 0);
        chk("midrst_rx_overflow", rx_overflow, 0);
        chk("midrst_tx_overflow", tx_overflow, 0);
        chk("midrst_rx_ready", rx_ready, 0);
        chk("midrst_rdata", rdata, 0);
        repeat (3) step();
        chk("midrst_tx_stays_idle", tx_busy, 0);
        next = 1'b1; got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rx_ready) got = 1'b1;
        end
        chk("midrst_rx_fifo_empty", got, 0);
        next = 1'b0;
        step(); step();

        // Random TX traffic against the reference model, with a burst that overflows.
        for (int c = 0; c < 1500; c++) begin
            tx_ready = ((c >= 700 && c < 720) || ($urandom_range(0, 99) < 4));
            sdata = 8'($urandom);
            step();
        end
        tx_ready = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 1200 && !got; k++) begin
            step();
            if (m_busy == 0 && m_q.size() == 0) got = 1'b1;
        end
        chk("tx_random_drained", got, 1);
        step();
        chk("tx_random_idle", tx_busy, 0);

        // Random RX traffic with a well-behaved core and an in-order scoreboard.
        core_req = 1'b0; cool = 0; wcnt = 0;
        for (int c = 0; c < 1400; c++) begin
            if (c >= 800 && sb.size() == 0) break;
            rx_byte_valid = (c < 800) && (sb.size() < 15) && ($urandom_range(0, 9) < 3);
            if (rx_byte_valid) begin
                rx_byte = 8'($urandom);
                sb.push_back(rx_byte);
            end
            step();
            rx_byte_valid = 1'b0;
            if (rx_ready) begin
                chk("rx_rand_requested", core_req, 1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    chk("rx_rand_rdata", rdata, exp_b);
                end else begin
                    chk("rx_rand_spurious", rx_ready, 0);
                end
                core_req = 1'b0; next = 1'b0; cool = 2; wcnt = 0;
            end else if (cool > 0) begin
                cool--;
            end else if (!core_req && $urandom_range(0, 3) == 0) begin
                core_req = 1'b1; next = 1'b1;
            end
            if (core_req && sb.size() > 0) begin
                wcnt++;
                if (wcnt > 8) begin
                    chk("rx_rand_latency", wcnt, 0);
                    wcnt = 0;
                end
            end
        end
        next = 1'b0;
        chk("rx_rand_drained", sb.size(), 0);
        chk("rx_rand_no_overflow", rx_overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
